reflect_coeff_quant: RTL
========================

Name: reflect_coeff_quant

Overview:
- Parametrised successor to the single-coefficient reflection quantiser in the LPC linear-prediction chain.
- Accepts one frame of ORDER reflection coefficients from the Levinson-Durbin recursion. Scales each by SCALE with round-half-up and symmetric saturation.
- Emits the quantised lattice coefficient k and the derived coefficient b, tagged with coefficient index and end-of-frame.
- Full valid/ready backpressure so it can sit in front of the lattice-filter coefficient RAM.

Parameters:
- IN_W, 32: input coefficient width, signed.
- OUT_W, 16: output k/b width, signed.
- SCALE, 16'h7FF8: unsigned multiplier applied to the input.
- FRAC, 15: right shift after scaling; rounding constant is 2^(FRAC-1).
- ORDER, 10: coefficients per frame (>=2).
- B_OFFSET, 2: additive offset for the b path.
- B_SHIFT, 2: arithmetic right shift for the b path.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_k  in  IN_W  signed raw reflection coefficient
- in_valid  in  1  in_k valid
- in_ready  out  1  block accepts in_k this cycle
- out_k  out  OUT_W  signed quantised k
- out_b  out  OUT_W  signed b coefficient
- out_idx  out  $clog2(ORDER)  coefficient index within frame, 0..ORDER-1
- out_last  out  1  high with index ORDER-1
- out_sat  out  1  this coefficient's k was clamped
- out_valid  out  1  output valid
- out_ready  in  1  downstream accepts output

Behaviour:
- Reset (rst low, asynchronous): all pipeline registers and valids clear. out_k=0, out_b=0, out_idx=0, out_last=0, out_sat=0, out_valid=0, input index counter=0. in_ready is high one cycle after deassertion.
- Pipeline structure: 3 stages (S1 multiply, S2 round, S3 shift/saturate). Global enable en = !(out_valid && !out_ready). All stages advance only when en=1; stalled stages hold contents and valid bits.
- Input handshake: in_ready = en. A transfer occurs when in_valid && in_ready.
- Latency: 3 cycles from accepted input to out_valid when there is no backpressure. Throughput is 1 coefficient/cycle.
- S1: p = in_k * SCALE, computed at full IN_W+17-bit signed width with SCALE zero-extended. bt = low OUT_W bits of (in_k + B_OFFSET).
- S2: r = p + 2^(FRAC-1). bs = bt >>> B_SHIFT (arithmetic, OUT_W bits).
- S3: q = r >>> FRAC (floor).
  - If q > 2^(OUT_W-1)-1: out_k = 2^(OUT_W-1)-1, out_sat=1.
  - If q < -(2^(OUT_W-1)-1): out_k = -(2^(OUT_W-1)-1), out_sat=1. The range is symmetric; the most-negative code is never emitted, preserving |k|<1 for lattice stability.
  - Otherwise out_k = q, out_sat=0.
  - out_b = bs.
- Index: a counter increments on each accepted input and wraps ORDER-1 -> 0. Its value travels down the pipeline with the data to form out_idx; out_last = (idx == ORDER-1).
- Output: out_valid remains asserted, with all outputs stable, until out_ready. When out_valid=0, out_k/out_b/out_idx hold their last values.
- Simultaneous output transfer and input acceptance in the same cycle is permitted with no bubble.
- Reset mid-frame: the frame is discarded and the index restarts at 0.
- There is no mid-frame resynchronisation other than reset.

Optional Feature:
- Macro: REFL_STICKY_SAT_EN.
- Defined: adds output port frame_sat (1 bit). It is the OR of out_sat over all coefficients of the current frame up to and including the present output. It is valid with out_valid and is final on out_last. The internal accumulator clears after the out_last transfer and on reset.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Nominal positive: in_k=32'h00004000, out_ready=1 -> 3 cycles later out_k=16'h3FFC, out_b=16'h1000, out_sat=0, out_idx=0.
- Nominal negative: in_k=32'hFFFFC000 -> out_k=16'hC004, out_b=16'hF000, out_sat=0.
- Saturation: in_k=32'h00010000 -> out_k=16'h7FFF, out_sat=1; in_k=32'hFFFF0000 -> out_k=16'h8001, out_sat=1. With REFL_STICKY_SAT_EN, frame_sat=1 through out_last.
- Frame tagging: stream 2*ORDER back-to-back inputs -> out_idx runs 0..9,0..9; out_last high exactly at idx 9 both times; no gaps.
- Backpressure: hold out_ready=0 for 5 cycles during a stream -> in_ready=0 while stalled; out_* stable; no loss or duplication; order preserved on release.
- Async reset mid-frame: assert rst low between clock edges after 4 inputs -> out_valid drops immediately; the next accepted input emerges with out_idx=0.

Source files
------------

// File: rtl/reflect_coeff_quant.sv
// Reflection-coefficient quantiser: 3-stage scale/round/saturate pipeline with frame index tagging.
// Optional REFL_STICKY_SAT_EN adds frame_sat, the running OR of out_sat across the current frame.
module reflect_coeff_quant #(
  parameter int          IN_W     = 32,
  parameter int          OUT_W    = 16,
  parameter logic [15:0] SCALE    = 16'h7FF8,
  parameter int          FRAC     = 15,
  parameter int          ORDER    = 10,
  parameter int          B_OFFSET = 2,
  parameter int          B_SHIFT  = 2,
  localparam int         IDX_W    = $clog2(ORDER),
  localparam int         P_W      = IN_W + 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_k,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_k,
  output logic [OUT_W-1:0] out_b,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready
`ifdef REFL_STICKY_SAT_EN
  , output logic           frame_sat
`endif
);

  localparam logic signed [P_W-1:0] RND       = P_W'(64'd1 << (FRAC - 1));
  localparam logic signed [P_W-1:0] K_MAX     = P_W'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [P_W-1:0] K_MIN     = -K_MAX;
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(ORDER - 1);
  localparam logic [IDX_W-1:0]      IDX_ZERO  = {IDX_W{1'b0}};

  // Symmetric clamp: returns {sat, k}; the most-negative code is never produced.
  function automatic logic [OUT_W:0] sat_k(input logic signed [P_W-1:0] q);
    logic [OUT_W:0] res;
    if (q > K_MAX) begin
      res = {1'b1, K_MAX[OUT_W-1:0]};
    end else if (q < K_MIN) begin
      res = {1'b1, K_MIN[OUT_W-1:0]};
    end else begin
      res = {1'b0, q[OUT_W-1:0]};
    end
    return res;
  endfunction

  logic                    en_s, in_xfer_s, s1_ld_s, s2_ld_s, s3_ld_s;
  logic signed [P_W-1:0]   ink_ext_s, scale_ext_s, p_s, q_s;
  logic [OUT_W-1:0]        bt_s;
  logic [OUT_W:0]          ksat_s;

  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, out_valid_q, out_valid_d;
  logic signed [P_W-1:0]   s1_p_q, s1_p_d, s2_r_q, s2_r_d;
  logic [OUT_W-1:0]        s1_bt_q, s1_bt_d, s2_bs_q, s2_bs_d;
  logic [IDX_W-1:0]        s1_idx_q, s1_idx_d, s2_idx_q, s2_idx_d, out_idx_q, out_idx_d;
  logic [OUT_W-1:0]        out_k_q, out_k_d, out_b_q, out_b_d;
  logic                    out_last_q, out_last_d, out_sat_q, out_sat_d;

  assign en_s      = !(out_valid_q && !out_ready);
  assign in_xfer_s = in_valid && en_s;
  assign s1_ld_s   = en_s && in_valid;
  assign s2_ld_s   = en_s && s1_valid_q;
  assign s3_ld_s   = en_s && s2_valid_q;

  assign ink_ext_s   = P_W'($signed(in_k));
  assign scale_ext_s = $signed({{(P_W-16){1'b0}}, SCALE});
  assign p_s         = ink_ext_s * scale_ext_s;
  assign bt_s        = OUT_W'(in_k + IN_W'(B_OFFSET));
  assign q_s         = s2_r_q >>> FRAC;
  assign ksat_s      = sat_k(q_s);

  // Next-state for index counter and all pipeline stages; stalled stages hold.
  always_comb begin
    idx_d       = idx_q;
    if (in_xfer_s) begin
      idx_d = (idx_q == IDX_LAST) ? IDX_ZERO : idx_q + IDX_W'(1);
    end else begin
      idx_d = idx_q;
    end
    s1_valid_d  = en_s ? in_valid   : s1_valid_q;
    s2_valid_d  = en_s ? s1_valid_q : s2_valid_q;
    out_valid_d = en_s ? s2_valid_q : out_valid_q;
    s1_p_d      = s1_ld_s ? p_s   : s1_p_q;
    s1_bt_d     = s1_ld_s ? bt_s  : s1_bt_q;
    s1_idx_d    = s1_ld_s ? idx_q : s1_idx_q;
    s2_r_d      = s2_ld_s ? s1_p_q + RND : s2_r_q;
    s2_bs_d     = s2_ld_s ? OUT_W'($signed(s1_bt_q) >>> B_SHIFT) : s2_bs_q;
    s2_idx_d    = s2_ld_s ? s1_idx_q : s2_idx_q;
    out_k_d     = s3_ld_s ? ksat_s[OUT_W-1:0] : out_k_q;
    out_sat_d   = s3_ld_s ? ksat_s[OUT_W]     : out_sat_q;
    out_b_d     = s3_ld_s ? s2_bs_q           : out_b_q;
    out_idx_d   = s3_ld_s ? s2_idx_q          : out_idx_q;
    out_last_d  = s3_ld_s ? (s2_idx_q == IDX_LAST) : out_last_q;
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q       <= IDX_ZERO;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_p_q      <= '0;
      s1_bt_q     <= '0;
      s1_idx_q    <= IDX_ZERO;
      s2_r_q      <= '0;
      s2_bs_q     <= '0;
      s2_idx_q    <= IDX_ZERO;
      out_k_q     <= '0;
      out_b_q     <= '0;
      out_idx_q   <= IDX_ZERO;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      s1_p_q      <= s1_p_d;
      s1_bt_q     <= s1_bt_d;
      s1_idx_q    <= s1_idx_d;
      s2_r_q      <= s2_r_d;
      s2_bs_q     <= s2_bs_d;
      s2_idx_q    <= s2_idx_d;
      out_k_q     <= out_k_d;
      out_b_q     <= out_b_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = en_s;
  assign out_k     = out_k_q;
  assign out_b     = out_b_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;

`ifdef REFL_STICKY_SAT_EN
  logic acc_q, acc_d, frame_sat_q, frame_sat_d, fs_base_s;

  // acc_q holds the OR of already-transferred outputs of the open frame.
  always_comb begin
    fs_base_s   = out_valid_q ? (out_last_q ? 1'b0 : frame_sat_q) : acc_q;
    frame_sat_d = s3_ld_s ? (fs_base_s | ksat_s[OUT_W]) : frame_sat_q;
    acc_d       = (out_valid_q && out_ready) ? (out_last_q ? 1'b0 : frame_sat_q) : acc_q;
  end

  // Sticky saturation registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q       <= 1'b0;
      frame_sat_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      frame_sat_q <= frame_sat_d;
    end
  end

  assign frame_sat = frame_sat_q;
`endif

endmodule
